// File: rtl/nrn_pkg.sv
// Shared types and sizes for the neuron controller: FSM state encoding,
// fan-in and byte width, plus a helper that slices one bit out of every lane.
package nrn_pkg;

  localparam int NRN_FANIN = 4;
  localparam int BYTE_W    = 8;
  localparam int VEC_W     = NRN_FANIN * BYTE_W;
  localparam int BIT_CNT_W = $clog2(BYTE_W);
  localparam int WAIT_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_REQ = 3'd1,
    ST_STREAM   = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_COLLECT  = 3'd4,
    ST_DONE     = 3'd5
  } nrn_state_e;

  // Bit k of every input byte, lane i taken from vec[8i+7:8i].
  function automatic logic [NRN_FANIN-1:0] lane_bits(
    input logic [VEC_W-1:0]     vec,
    input logic [BIT_CNT_W-1:0] k
  );
    logic [NRN_FANIN-1:0] b;
    logic [BYTE_W-1:0]    byte_v;
    b = '0;
    for (int i = 0; i < NRN_FANIN; i++) begin
      byte_v = vec[i*BYTE_W +: BYTE_W];
      b[i]   = byte_v[k];
    end
    return b;
  endfunction

endpackage

// File: rtl/nrn_wait_timer.sv
// Wait-state watchdog. The count is held at zero while clear_i is high and
// advances once per enabled cycle. expired_o flags the cycle whose closing
// edge is the TIMEOUT-th edge spent waiting; the count saturates there so it
// never wraps.
module nrn_wait_timer
  import nrn_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  enable_i,
  output logic                  expired_o,
  output logic [WAIT_CNT_W-1:0] count_o
);

  localparam logic [WAIT_CNT_W-1:0] LAST = WAIT_CNT_W'(TIMEOUT - 1);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up while enabled, stop at LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + WAIT_CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && !clear_i && (cnt_q == LAST);
  assign count_o   = cnt_q;

endmodule

// File: rtl/neuron_ctrl.sv
// Neuron controller: accepts a 4-byte vector from the host, streams it
// bit-serially (LSB first) into four neuron input lanes, collects the 8-bit
// serial result and offers it back to the host. Waits for the neuron are
// guarded by a watchdog that aborts with a one-cycle ERR pulse.
//
// Handshakes: a host transfer happens on a rising edge where both valid and
// ready are high. in_ready_o is high only in IDLE; res_valid_o is high only
// in DONE and res_data_o is stable until res_ready_i is seen. A result
// handshake and a new input accept never share an edge.
//
// All outputs are registers loaded from the next-state values, so an output
// reflects the state entered at the same edge.
module neuron_ctrl
  import nrn_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [VEC_W-1:0]     in_data_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [BYTE_W-1:0]    res_data_o,
  output logic                 err_o,
  output logic                 busy_o,
  input  logic [NRN_FANIN-1:0] nrn_in_req_i,
  output logic [NRN_FANIN-1:0] nrn_in_ack_o,
  output logic [NRN_FANIN-1:0] nrn_in_data_o,
  output logic                 nrn_out_req_o,
  input  logic                 nrn_out_ack_i,
  input  logic                 nrn_out_data_i,
  output nrn_state_e           state_o
);

  nrn_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] k_q, k_d;
  logic [VEC_W-1:0]     vec_q, vec_d;
  logic [BYTE_W-1:0]    sh_q, sh_d;
  logic [BYTE_W-1:0]    res_data_q, res_data_d;

  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 res_valid_q, res_valid_d;
  logic                 out_req_q, out_req_d;
  logic [NRN_FANIN-1:0] ack_q, ack_d;
  logic [NRN_FANIN-1:0] lane_q, lane_d;

  logic                  in_wait;
  logic                  expired;
  logic [WAIT_CNT_W-1:0] wait_count;

  assign in_wait = (state_q == ST_WAIT_REQ) || (state_q == ST_WAIT_ACK);

  nrn_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (!in_wait),
    .enable_i  (in_wait),
    .expired_o (expired),
    .count_o   (wait_count)
  );

  // Next-state logic; the awaited condition is tested before the timeout so
  // it wins when both occur together.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    vec_d      = vec_q;
    sh_d       = sh_q;
    res_data_d = res_data_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          vec_d   = in_data_i;
          state_d = ST_WAIT_REQ;
        end
      end
      ST_WAIT_REQ: begin
        if (&nrn_in_req_i) begin
          k_d     = '0;
          state_d = ST_STREAM;
        end else if (expired) begin
          vec_d   = '0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (k_q == BIT_CNT_W'(BYTE_W - 1)) begin
          k_d     = '0;
          state_d = ST_WAIT_ACK;
        end else begin
          k_d = k_q + BIT_CNT_W'(1);
        end
      end
      ST_WAIT_ACK: begin
        if (nrn_out_ack_i) begin
          sh_d[0] = nrn_out_data_i;
          k_d     = BIT_CNT_W'(1);
          state_d = ST_COLLECT;
        end else if (expired) begin
          vec_d   = '0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        // nrn_out_ack_i is deliberately not looked at here.
        sh_d[k_q] = nrn_out_data_i;
        if (k_q == BIT_CNT_W'(BYTE_W - 1)) begin
          res_data_d = {nrn_out_data_i, sh_q[BYTE_W-2:0]};
          k_d        = '0;
          state_d    = ST_DONE;
        end else begin
          k_d = k_q + BIT_CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (res_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the state being entered.
  always_comb begin
    in_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    res_valid_d = (state_d == ST_DONE);
    out_req_d   = (state_d == ST_WAIT_ACK);
    ack_d       = '0;
    lane_d      = '0;
    if (state_d == ST_STREAM) begin
      lane_d = lane_bits(vec_q, k_d);
      if (k_d == '0) begin
        ack_d = '1;
      end
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      vec_q       <= '0;
      sh_q        <= '0;
      res_data_q  <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      out_req_q   <= 1'b0;
      ack_q       <= '0;
      lane_q      <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      vec_q       <= vec_d;
      sh_q        <= sh_d;
      res_data_q  <= res_data_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      out_req_q   <= out_req_d;
      ack_q       <= ack_d;
      lane_q      <= lane_d;
    end
  end

  assign in_ready_o    = in_ready_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;
  assign res_valid_o   = res_valid_q;
  assign res_data_o    = res_data_q;
  assign nrn_out_req_o = out_req_q;
  assign nrn_in_ack_o  = ack_q;
  assign nrn_in_data_o = lane_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_neuron_ctrl.sv
// Directed bench for neuron_ctrl built with a short watchdog (TIMEOUT=16).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_neuron_ctrl;
  import nrn_pkg::*;

  localparam int unsigned TMO = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [VEC_W-1:0]     in_data;
  logic                 res_valid;
  logic                 res_ready;
  logic [BYTE_W-1:0]    res_data;
  logic                 err;
  logic                 busy;
  logic [NRN_FANIN-1:0] nrn_in_req;
  logic [NRN_FANIN-1:0] nrn_in_ack;
  logic [NRN_FANIN-1:0] nrn_in_data;
  logic                 nrn_out_req;
  logic                 nrn_out_ack;
  logic                 nrn_out_data;
  nrn_state_e           state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [3:0] exp_lane [8];
  logic       exp_l0   [8];
  logic       exp_l3   [8];

  neuron_ctrl #(.TIMEOUT(TMO)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_data_i      (in_data),
    .res_valid_o    (res_valid),
    .res_ready_i    (res_ready),
    .res_data_o     (res_data),
    .err_o          (err),
    .busy_o         (busy),
    .nrn_in_req_i   (nrn_in_req),
    .nrn_in_ack_o   (nrn_in_ack),
    .nrn_in_data_o  (nrn_in_data),
    .nrn_out_req_o  (nrn_out_req),
    .nrn_out_ack_i  (nrn_out_ack),
    .nrn_out_data_i (nrn_out_data),
    .state_o        (state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),    32'd1);
    chk({tag, "_busy"},      32'(busy),        32'd0);
    chk({tag, "_err"},       32'(err),         32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid),   32'd0);
    chk({tag, "_res_data"},  32'(res_data),    32'd0);
    chk({tag, "_in_ack"},    32'(nrn_in_ack),  32'd0);
    chk({tag, "_in_data"},   32'(nrn_in_data), 32'd0);
    chk({tag, "_out_req"},   32'(nrn_out_req), 32'd0);
  endtask

  // Offer a vector with all lanes requesting; returns in STREAM k=0.
  task automatic start_vector(input logic [VEC_W-1:0] v);
    in_valid   = 1'b1;
    in_data    = v;
    nrn_in_req = 4'hF;
    step();
    in_valid   = 1'b0;
    step();
  endtask

  // Neuron output model: ACK with bit 0, then bits 1..7 on consecutive
  // cycles; ACK is toggled during the collect phase and must be ignored.
  task automatic send_result(input logic [7:0] r);
    nrn_out_ack  = 1'b1;
    nrn_out_data = r[0];
    step();
    chk("collect_out_req", 32'(nrn_out_req), 32'd0);
    chk("collect_err",     32'(err),         32'd0);
    for (int j = 1; j < 8; j++) begin
      nrn_out_data = r[j];
      nrn_out_ack  = j[0];
      step();
    end
    nrn_out_ack  = 1'b0;
    nrn_out_data = 1'b0;
  endtask

  initial begin
    exp_lane = '{4'h5, 4'h6, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    exp_l0   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_l3   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    res_ready    = 1'b0;
    nrn_in_req   = '0;
    nrn_out_ack  = 1'b0;
    nrn_out_data = 1'b0;

    // Reset held 3 cycles.
    repeat (3) step();
    chk_reset_vals("reset");
    chk("reset_state", 32'(state), 32'(ST_IDLE));
    rst = 1'b0;

    // Stream 04_03_02_01 with all lanes already requesting.
    in_valid   = 1'b1;
    in_data    = 32'h04_03_02_01;
    nrn_in_req = 4'hF;
    step();
    chk("wreq_in_ready", 32'(in_ready),   32'd0);
    chk("wreq_busy",     32'(busy),       32'd1);
    chk("wreq_ack",      32'(nrn_in_ack), 32'd0);
    in_valid = 1'b0;
    step();
    for (int k = 0; k < 8; k++) begin
      chk("stream_ack",   32'(nrn_in_ack),     (k == 0) ? 32'hF : 32'h0);
      chk("stream_lane0", 32'(nrn_in_data[0]), 32'(exp_l0[k]));
      chk("stream_lane3", 32'(nrn_in_data[3]), 32'(exp_l3[k]));
      chk("stream_lanes", 32'(nrn_in_data),    32'(exp_lane[k]));
      step();
    end
    chk("wack_out_req", 32'(nrn_out_req), 32'd1);
    chk("wack_lanes",   32'(nrn_in_data), 32'd0);
    step();
    step();
    chk("wack_out_req_hold", 32'(nrn_out_req), 32'd1);

    // Collect 8'h2D and hold it while the host stalls.
    send_result(8'h2D);
    chk("done_res_valid", 32'(res_valid), 32'd1);
    chk("done_res_data",  32'(res_data),  32'h2D);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_res_valid", 32'(res_valid), 32'd1);
      chk("stall_res_data",  32'(res_data),  32'h2D);
    end

    // Result handshake with IN_VALID already high: no accept on that edge.
    res_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hFF_00_FF_00;
    step();
    chk("ret_res_valid", 32'(res_valid), 32'd0);
    chk("ret_in_ready",  32'(in_ready),  32'd1);
    chk("ret_busy",      32'(busy),      32'd0);
    res_ready  = 1'b0;

    // Partial request mask for 10 cycles, then full.
    nrn_in_req = 4'b0111;
    step();
    chk("partial_accept_busy", 32'(busy),     32'd1);
    chk("partial_in_ready",    32'(in_ready), 32'd0);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("partial_no_ack", 32'(nrn_in_ack), 32'd0);
      step();
    end
    nrn_in_req = 4'hF;
    step();
    chk("full_req_ack",   32'(nrn_in_ack),  32'hF);
    chk("full_req_lanes", 32'(nrn_in_data), 32'hA);

    // WAIT_ACK timeout: ERR on the 16th edge after entry.
    repeat (8) step();
    chk("tmo_out_req_entry", 32'(nrn_out_req), 32'd1);
    repeat (15) step();
    chk("tmo_err_early", 32'(err),         32'd0);
    chk("tmo_req_early", 32'(nrn_out_req), 32'd1);
    step();
    chk("tmo_err",      32'(err),         32'd1);
    chk("tmo_out_req",  32'(nrn_out_req), 32'd0);
    chk("tmo_in_ready", 32'(in_ready),    32'd1);
    chk("tmo_busy",     32'(busy),        32'd0);
    chk("tmo_res_data", 32'(res_data),    32'h2D);
    step();
    chk("tmo_err_pulse", 32'(err),      32'd0);
    chk("tmo_ready_hold", 32'(in_ready), 32'd1);

    // ACK on the very edge the watchdog would fire: ACK wins.
    start_vector(32'h01_01_01_01);
    repeat (8) step();
    repeat (15) step();
    send_result(8'hC3);
    chk("race_res_valid", 32'(res_valid), 32'd1);
    chk("race_res_data",  32'(res_data),  32'hC3);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("race_idle", 32'(in_ready), 32'd1);

    // WAIT_REQ timeout with no lane requesting.
    in_valid   = 1'b1;
    in_data    = 32'h11_22_33_44;
    nrn_in_req = 4'h0;
    step();
    in_valid = 1'b0;
    repeat (15) step();
    chk("wreq_tmo_err_early", 32'(err),  32'd0);
    chk("wreq_tmo_busy",      32'(busy), 32'd1);
    step();
    chk("wreq_tmo_err",      32'(err),         32'd1);
    chk("wreq_tmo_in_ready", 32'(in_ready),    32'd1);
    chk("wreq_tmo_no_ack",   32'(nrn_in_ack),  32'd0);
    chk("wreq_tmo_res_data", 32'(res_data),    32'hC3);

    // Reset in the middle of STREAM (k=4), then a normal transaction.
    start_vector(32'h04_03_02_01);
    repeat (4) step();
    chk("mid_state_stream", 32'(state), 32'(ST_STREAM));
    rst = 1'b1;
    step();
    chk_reset_vals("midrst");
    rst = 1'b0;
    start_vector(32'h04_03_02_01);
    chk("post_rst_ack",   32'(nrn_in_ack),  32'hF);
    chk("post_rst_lanes", 32'(nrn_in_data), 32'h5);
    repeat (8) step();
    send_result(8'h5A);
    chk("post_rst_res_valid", 32'(res_valid), 32'd1);
    chk("post_rst_res_data",  32'(res_data),  32'h5A);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("post_rst_idle_ready", 32'(in_ready), 32'd1);
    chk("post_rst_idle_busy",  32'(busy),     32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
